fifo_wptr_full: RTL and testbench

Write-domain pointer and full-flag generator for the team's asynchronous FIFO. It accepts write requests, maintains the binary and Gray write pointers, and produces the RAM write address. It compares its next Gray pointer against the read pointer that has already been synchronized into the write clock domain (`rq2_raddr`), and generates registered full, almost-full and fill-level outputs. It sits directly upstream of the pointer synchronizer: its `waddr_gray` output feeds the synchronizer's write-pointer input, and it consumes the synchronizer's `rq2_raddr` output.

---
 rtl/fifo_wptr_full.sv | 87 ++++++++
 tb/tb_fifo_wptr_full.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-domain pointer and full/almost-full/level generator
// for the asynchronous FIFO. The binary and Gray write pointers are kept in
// the clk domain. Flags are registered from a compare against the read
// pointer, which arrives already synchronized in Gray code.
// Optional: define FIFO_WOVERFLOW_EN to add the sticky woverflow output.
module fifo_wptr_full #(
  parameter int PTR_SZ       = 2,
  parameter int AFULL_THRESH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              winc,
  input  logic [PTR_SZ:0]   rq2_raddr,
  output logic [PTR_SZ-1:0] waddr,
  output logic [PTR_SZ:0]   waddr_gray,
  output logic              wfull,
  output logic              walmost_full,
  output logic [PTR_SZ:0]   wlevel
`ifdef FIFO_WOVERFLOW_EN
  ,
  output logic              woverflow
`endif
);

  localparam logic [PTR_SZ:0] AFULL_LVL = (PTR_SZ+1)'(AFULL_THRESH);

  logic [PTR_SZ:0] wbin;
  logic [PTR_SZ:0] wbin_next;
  logic [PTR_SZ:0] wgray_next;
  logic [PTR_SZ:0] rbin;
  logic [PTR_SZ:0] level_next;
  logic            accepted;
  logic            full_next;
  logic            afull_next;

  // Gray-to-binary conversion of the synchronized read pointer, XOR prefix from the MSB down
  always_comb begin
    rbin         = '0;
    rbin[PTR_SZ] = rq2_raddr[PTR_SZ];
    for (int unsigned i = 0; i < PTR_SZ; i++) begin
      rbin[PTR_SZ-1-i] = rbin[PTR_SZ-i] ^ rq2_raddr[PTR_SZ-1-i];
    end
  end

  // Next pointer, next Gray code and next flag values
  always_comb begin
    accepted   = winc && !wfull;
    wbin_next  = wbin + (PTR_SZ+1)'(accepted);
    wgray_next = (wbin_next >> 1) ^ wbin_next;
    // Full when the write pointer leads the read pointer by exactly one
    // depth. In Gray code that means the two MSBs differ and the rest match.
    full_next  = (wgray_next == {~rq2_raddr[PTR_SZ:PTR_SZ-1], rq2_raddr[PTR_SZ-2:0]});
    level_next = wbin_next - rbin;
    afull_next = (level_next >= AFULL_LVL);
  end

  // Pointer and flag registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      wbin         <= '0;
      waddr_gray   <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wbin         <= wbin_next;
      waddr_gray   <= wgray_next;
      wfull        <= full_next;
      walmost_full <= afull_next;
      wlevel       <= level_next;
    end
  end

  assign waddr = wbin[PTR_SZ-1:0];

`ifdef FIFO_WOVERFLOW_EN
  // Sticky overflow: set by any write attempt while full, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      woverflow <= 1'b0;
    end else if (winc && wfull) begin
      woverflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full: directed and randomized bench for fifo_wptr_full.
// The reference tracks the total counts of written and read words as plain
// integers and derives every expected output from those counts.
module tb_fifo_wptr_full;

  localparam int PTR_SZ = 2;
  localparam int THRESH = 3;
  localparam int DEPTH  = 1 << PTR_SZ;

  logic              clk = 1'b0;
  logic              rst;
  logic              winc;
  logic [PTR_SZ:0]   rq2_raddr;
  logic [PTR_SZ-1:0] waddr;
  logic [PTR_SZ:0]   waddr_gray;
  logic              wfull;
  logic              walmost_full;
  logic [PTR_SZ:0]   wlevel;
`ifdef FIFO_WOVERFLOW_EN
  logic              woverflow;
`endif

  fifo_wptr_full #(.PTR_SZ(PTR_SZ), .AFULL_THRESH(THRESH)) dut (
    .clk          (clk),
    .rst          (rst),
    .winc         (winc),
    .rq2_raddr    (rq2_raddr),
    .waddr        (waddr),
    .waddr_gray   (waddr_gray),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel)
`ifdef FIFO_WOVERFLOW_EN
    ,
    .woverflow    (woverflow)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: total words written and read since the last reset
  int wr_cnt   = 0;
  int rd_cnt   = 0;
  bit exp_full = 1'b0;
  bit exp_ovf  = 1'b0;

  function automatic logic [PTR_SZ:0] to_gray(input int cnt);
    int b;
    b = cnt % (2 * DEPTH);
    return (PTR_SZ+1)'(b ^ (b >> 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int lvl;
    lvl = wr_cnt - rd_cnt;
    chk("waddr",        32'(waddr),        32'(wr_cnt % DEPTH));
    chk("waddr_gray",   32'(waddr_gray),   32'(to_gray(wr_cnt)));
    chk("wlevel",       32'(wlevel),       32'(lvl));
    chk("wfull",        32'(wfull),        32'(lvl == DEPTH));
    chk("walmost_full", 32'(walmost_full), 32'(lvl >= THRESH));
`ifdef FIFO_WOVERFLOW_EN
    chk("woverflow",    32'(woverflow),    32'(exp_ovf));
`endif
  endtask

  // One clock: drive inputs mid-cycle, advance the reference at the edge, check after it
  task automatic step(input logic r, input logic w, input int rd_new);
    @(negedge clk);
    rst       = r;
    winc      = w;
    rd_cnt    = rd_new;
    rq2_raddr = to_gray(rd_new);
    @(posedge clk);
    if (!r) begin
      wr_cnt  = 0;
      rd_cnt  = 0;
      exp_ovf = 1'b0;
    end else begin
      if (w && exp_full) exp_ovf = 1'b1;
      if (w && !exp_full) wr_cnt++;
    end
    exp_full = ((wr_cnt - rd_cnt) == DEPTH);
    #1;
    check_all();
  endtask

  logic [PTR_SZ:0] fill_gray [4] = '{3'b001, 3'b011, 3'b010, 3'b110};
  logic [PTR_SZ:0] wrap_gray [4] = '{3'b111, 3'b101, 3'b100, 3'b000};

  initial begin
    rst       = 1'b0;
    winc      = 1'b1;
    rq2_raddr = '0;

    // Reset held for two clocks with winc asserted
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 0);
    chk("reset_gray", 32'(waddr_gray), 32'd0);

    // Fill from empty
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 0);
      chk("fill_gray",  32'(waddr_gray), 32'(fill_gray[i]));
      chk("fill_level", 32'(wlevel),     32'(i + 1));
    end
    chk("fill_full", 32'(wfull), 32'd1);

    // Write while full is dropped
    step(1'b1, 1'b1, 0);
    chk("full_hold_gray", 32'(waddr_gray), 32'b110);
    step(1'b1, 1'b0, 0);

    // Drain everything, then refill across the wrap
    step(1'b1, 1'b0, 4);
    chk("drain_full",  32'(wfull),  32'd0);
    chk("drain_level", 32'(wlevel), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 4);
      chk("wrap_gray", 32'(waddr_gray), 32'(wrap_gray[i]));
    end
    chk("wrap_full", 32'(wfull), 32'd1);

    // Read pointer advances in the same cycle as a refused write
    step(1'b1, 1'b1, 5);
    chk("simul_gray", 32'(waddr_gray), 32'b000);
    chk("simul_full", 32'(wfull),      32'd0);
    step(1'b1, 1'b1, 5);
    chk("simul_level", 32'(wlevel), 32'd4);

    // Mid-operation reset at level 3
    step(1'b1, 1'b0, 6);
    chk("pre_rst_level", 32'(wlevel), 32'd3);
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 0);
    chk("post_rst_gray", 32'(waddr_gray), 32'b001);

    // Randomized traffic with a monotonic read pointer that never passes the writes
    for (int n = 0; n < 400; n++) begin
      int  rd_new;
      logic r;
      logic w;
      r      = ($urandom_range(99, 0) != 0);
      w      = ($urandom_range(3, 0) != 0);
      rd_new = rd_cnt;
      if ($urandom_range(2, 0) == 0)
        rd_new = rd_cnt + int'($urandom_range(32'(wr_cnt - rd_cnt), 0));
      if (!r) rd_new = 0;
      step(r, w, rd_new);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
